// File: rtl/wb_write_buffer.sv
// In-order register write-back buffer: queues writes while the register-file port is busy.
// Define WB_BYPASS_EN to build the src1/src2 lookup; otherwise hit/fwd outputs are tied to 0.
module wb_write_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_dest,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   drain_hold,
  output logic                   writeBackEn,
  output logic [ADDR_W-1:0]      dest_wb,
  output logic [DATA_W-1:0]      result_WB,
  input  logic [ADDR_W-1:0]      src1,
  input  logic [ADDR_W-1:0]      src2,
  output logic                   hit1,
  output logic                   hit2,
  output logic [DATA_W-1:0]      fwd1,
  output logic [DATA_W-1:0]      fwd2,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              push;
  logic              pop;

  // Flow control depends only on registered occupancy, so a pop never frees a slot the same cycle.
  assign empty       = (count_reg == '0);
  assign in_ready    = (count_reg < CNT_W'(DEPTH));
  assign writeBackEn = !empty && !drain_hold;
  assign dest_wb     = empty ? '0 : dest_mem[head_reg];
  assign result_WB   = empty ? '0 : data_mem[head_reg];
  assign count       = count_reg;

  assign push = in_valid && in_ready;
  assign pop  = writeBackEn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        dest_mem[tail_reg] <= in_dest;
        data_mem[tail_reg] <= in_data;
        tail_reg           <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] lookup_idx;

  // Walk entries oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit1       = 1'b0;
    hit2       = 1'b0;
    fwd1       = '0;
    fwd2       = '0;
    lookup_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx = head_reg + PTR_W'(i);
      if (CNT_W'(i) < count_reg) begin
        if (dest_mem[lookup_idx] == src1) begin
          hit1 = 1'b1;
          fwd1 = data_mem[lookup_idx];
        end
        if (dest_mem[lookup_idx] == src2) begin
          hit2 = 1'b1;
          fwd2 = data_mem[lookup_idx];
        end
      end
    end
  end
`else
  logic unused_src;

  assign unused_src = ^{src1, src2};
  assign hit1       = 1'b0;
  assign hit2       = 1'b0;
  assign fwd1       = '0;
  assign fwd2       = '0;
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Self-checking bench for wb_write_buffer against a queue-based model of the pending writes.
module tb_wb_write_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              drain_hold = 1'b0;
  logic              writeBackEn;
  logic [ADDR_W-1:0] dest_wb;
  logic [DATA_W-1:0] result_WB;
  logic [ADDR_W-1:0] src1 = '0;
  logic [ADDR_W-1:0] src2 = '0;
  logic              hit1, hit2;
  logic [DATA_W-1:0] fwd1, fwd2;
  logic [$clog2(DEPTH):0] count;
  logic              empty;

  int total = 0;
  int bad   = 0;

  // Model: pending writes, oldest at index 0.
  logic [ADDR_W-1:0] q_dest[$];
  logic [DATA_W-1:0] q_data[$];

  wb_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_data(in_data),
    .drain_hold(drain_hold), .writeBackEn(writeBackEn), .dest_wb(dest_wb), .result_WB(result_WB),
    .src1(src1), .src2(src2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Youngest pending data for address s, with the hit flag in the top bit.
  function automatic logic [DATA_W:0] model_lookup(input logic [ADDR_W-1:0] s);
    logic [DATA_W:0] r;
    r = '0;
    if (BYP) begin
      foreach (q_dest[k]) if (q_dest[k] == s) r = {1'b1, q_data[k]};
    end
    return r;
  endfunction

  // One clock: model accepts/retires exactly what the rules allow, then settle after the falling edge.
  task automatic advance();
    bit do_push, do_pop;
    do_push = in_valid && (q_dest.size() < DEPTH);
    do_pop  = (q_dest.size() > 0) && !drain_hold;
    @(posedge clk);
    if (do_pop) begin
      void'(q_dest.pop_front());
      void'(q_data.pop_front());
    end
    if (do_push) begin
      q_dest.push_back(in_dest);
      q_data.push_back(in_data);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_dest = '0; in_data = 32'h5a5a;
    repeat (2) @(negedge clk);
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (writeBackEn !== 1'b0) begin bad++; $display("FAIL reset_wben: got %b want 0", writeBackEn); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (dest_wb !== '0 || result_WB !== '0) begin bad++; $display("FAIL reset_wb_bus: got %0h/%0h want 0/0", dest_wb, result_WB); end
    total++; if ({hit1, hit2} !== 2'b00 || fwd1 !== '0 || fwd2 !== '0) begin bad++; $display("FAIL reset_lookup: got hit %b%b fwd %0h/%0h want 0", hit1, hit2, fwd1, fwd2); end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    drain_hold = 1'b1; in_valid = 1'b1; in_dest = 4'd3; in_data = 32'h11;
    #1;
    total++; if (writeBackEn !== 1'b0) begin bad++; $display("FAIL single_no_cut_through: got %b want 0", writeBackEn); end
    advance();
    in_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
    total++; if (writeBackEn !== 1'b0) begin bad++; $display("FAIL single_hold: got %b want 0", writeBackEn); end
    drain_hold = 1'b0; #1;
    total++; if (writeBackEn !== 1'b1 || dest_wb !== 4'd3 || result_WB !== 32'h11)
      begin bad++; $display("FAIL single_write: got en=%b dest=%0d data=%0h want 1/3/11", writeBackEn, dest_wb, result_WB); end
    advance();
    total++; if (empty !== 1'b1 || writeBackEn !== 1'b0) begin bad++; $display("FAIL single_drained: got empty=%b en=%b want 1/0", empty, writeBackEn); end
  endtask

  task automatic test_full();
    logic [ADDR_W-1:0] exp_d[4];
    logic [DATA_W-1:0] exp_v[4];
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dest = ADDR_W'(10 + i); in_data = $urandom;
      exp_d[i] = in_dest; exp_v[i] = in_data;
      advance();
    end
    total++; if (in_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_state: got ready=%b count=%0d want 0/4", in_ready, count); end
    in_dest = 4'd9; in_data = 32'hdead;
    advance();
    total++; if (count !== 3'd4) begin bad++; $display("FAIL full_reject: got count=%0d want 4", count); end
    // Pop while full with a request still offered: only the pop happens.
    drain_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (writeBackEn !== 1'b1 || dest_wb !== exp_d[i] || result_WB !== exp_v[i])
        begin bad++; $display("FAIL full_drain_%0d: got en=%b %0h/%0h want 1 %0h/%0h", i, writeBackEn, dest_wb, result_WB, exp_d[i], exp_v[i]); end
      advance();
      if (i == 0) begin
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_no_push_on_pop: got count=%0d want 3", count); end
        in_valid = 1'b0;
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_empty: got %b want 1", empty); end
  endtask

  task automatic test_bypass();
    logic [DATA_W:0] e1, e2;
    drain_hold = 1'b1;
    in_valid = 1'b1; in_dest = 4'd5; in_data = 32'hA; advance();
    in_dest = 4'd5; in_data = 32'hB; advance();
    in_valid = 1'b0;
    src1 = 4'd5; src2 = 4'd6; #1;
    total++; if (hit1 !== BYP || fwd1 !== (BYP ? 32'hB : 32'h0)) begin bad++; $display("FAIL bypass_youngest: got %b/%0h want %b/%0h", hit1, fwd1, BYP, BYP ? 32'hB : 32'h0); end
    total++; if (hit2 !== 1'b0 || fwd2 !== '0) begin bad++; $display("FAIL bypass_miss: got %b/%0h want 0/0", hit2, fwd2); end
    drain_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      e1 = model_lookup(src1); e2 = model_lookup(src2);
      total++; if ({hit1, fwd1} !== e1 || {hit2, fwd2} !== e2) begin bad++; $display("FAIL bypass_drain_lookup_%0d: got %b/%0h %b/%0h want %b/%0h %b/%0h", i, hit1, fwd1, hit2, fwd2, e1[DATA_W], e1[DATA_W-1:0], e2[DATA_W], e2[DATA_W-1:0]); end
      if (i == 0) begin
        total++; if (writeBackEn !== 1'b1 || dest_wb !== 4'd5 || result_WB !== 32'hA) begin bad++; $display("FAIL bypass_drain_first: got %b %0h/%0h want 1 5/a", writeBackEn, dest_wb, result_WB); end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    drain_hold = 1'b1; in_valid = 1'b1;
    in_dest = 4'd1; in_data = 32'h100; advance();
    in_dest = 4'd2; in_data = 32'h200; advance();
    drain_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_dest = ADDR_W'(3 + i); in_data = 32'h1000 + i; #1;
      total++; if (writeBackEn !== 1'b1 || dest_wb !== q_dest[0] || result_WB !== q_data[0])
        begin bad++; $display("FAIL b2b_order_%0d: got en=%b %0h/%0h want 1 %0h/%0h", i, writeBackEn, dest_wb, result_WB, q_dest[0], q_data[0]); end
      advance();
      total++; if (count !== 3'd2) begin bad++; $display("FAIL b2b_count_%0d: got %0d want 2", i, count); end
    end
    in_valid = 1'b0;
    advance(); advance();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    drain_hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_dest = ADDR_W'(7 + i); in_data = $urandom; advance();
    end
    in_valid = 1'b0;
    total++; if (count !== 3'd3) begin bad++; $display("FAIL rstmid_count: got %0d want 3", count); end
    #2;
    drain_hold = 1'b0; rst = 1'b0;
    q_dest.delete(); q_data.delete();
    #1;
    total++; if (empty !== 1'b1 || writeBackEn !== 1'b0) begin bad++; $display("FAIL rstmid_async: got empty=%b en=%b want 1/0", empty, writeBackEn); end
    @(negedge clk); rst = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (writeBackEn !== 1'b0 || count !== '0) begin bad++; $display("FAIL rstmid_no_write_%0d: got en=%b count=%0d want 0/0", i, writeBackEn, count); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [DATA_W:0] e1, e2;
    int n;
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      drain_hold = ($urandom_range(0, 2) == 0);
      in_dest    = ADDR_W'($urandom_range(0, 5));
      in_data    = $urandom;
      src1       = ADDR_W'($urandom_range(0, 7));
      src2       = ADDR_W'($urandom_range(0, 7));
      #1;
      n  = q_dest.size();
      e1 = model_lookup(src1);
      e2 = model_lookup(src2);
      total++;
      if (count !== 3'(n) || empty !== (n == 0) || in_ready !== (n < DEPTH) ||
          writeBackEn !== (n > 0 && !drain_hold) ||
          dest_wb !== (n > 0 ? q_dest[0] : '0) || result_WB !== (n > 0 ? q_data[0] : '0) ||
          {hit1, fwd1} !== e1 || {hit2, fwd2} !== e2) begin
        bad++;
        $display("FAIL random_%0d: got cnt=%0d en=%b wb=%0h/%0h l1=%b/%0h l2=%b/%0h want cnt=%0d wb=%0h/%0h l1=%b/%0h l2=%b/%0h",
                 c, count, writeBackEn, dest_wb, result_WB, hit1, fwd1, hit2, fwd2,
                 n, n > 0 ? q_dest[0] : '0, n > 0 ? q_data[0] : '0,
                 e1[DATA_W], e1[DATA_W-1:0], e2[DATA_W], e2[DATA_W-1:0]);
      end
      advance();
    end
    in_valid = 1'b0; drain_hold = 1'b0;
    repeat (DEPTH + 1) advance();
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_write_buffer.md
WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width.
REQ-003 SHALL have parameter DEPTH, default 4, pending-write entries; power of 2, minimum 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  write request offered by pipeline.
REQ-007 SHALL have port in_ready  output  1  buffer can accept a request.
REQ-008 SHALL have port in_dest  input  ADDR_W  destination register of request.
REQ-009 SHALL have port in_data  input  DATA_W  value to be written.
REQ-010 SHALL have port drain_hold  input  1  register-file port busy; suppresses drain.
REQ-011 SHALL have port writeBackEn  output  1  register-file write enable.
REQ-012 SHALL have port dest_wb  output  ADDR_W  register-file write address.
REQ-013 SHALL have port result_WB  output  DATA_W  register-file write data.
REQ-014 SHALL have ports src1, src2  input  ADDR_W each  decode-stage read addresses for lookup.
REQ-015 SHALL have ports hit1, hit2  output  1 each  a pending entry targets srcN.
REQ-016 SHALL have ports fwd1, fwd2  output  DATA_W each  youngest pending data for srcN.
REQ-017 SHALL have port count  output  log2(DEPTH)+1  number of pending entries.
REQ-018 SHALL have port empty  output  1  count == 0.

Function
REQ-019 SHALL store requests in arrival order in a circular buffer with head/tail pointers wrapping modulo DEPTH.
REQ-020 SHALL drive in_ready = (count < DEPTH), from registered state only; no push when full, even if a pop occurs in the same cycle.
REQ-021 SHALL push {in_dest, in_data} at tail on a rising edge where in_valid && in_ready; tail advances by one.
REQ-022 SHALL drive writeBackEn = !empty && !drain_hold, combinationally, with dest_wb/result_WB equal to the head entry.
REQ-023 SHALL pop the head on a rising edge where writeBackEn = 1; head advances by one.
REQ-024 SHALL drive dest_wb = 0 and result_WB = 0 while empty.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged and move both pointers.
REQ-026 SHALL NOT cut through: a request pushed at edge N appears on writeBackEn no earlier than the cycle after edge N.
REQ-027 SHALL treat in_valid while !in_ready as not accepted; requester holds the request.
REQ-028 SHALL, for lookup, set hitN = 1 when any stored entry (including the head being written this cycle) has dest == srcN.
REQ-029 SHALL drive fwdN = data of the youngest matching entry, or 0 when hitN = 0; lookup is purely combinational.
REQ-030 SHALL give register addresses no special treatment; every address is writable.

Reset
REQ-031 SHALL, while rst = 0, clear head, tail and count to 0 and all entry storage to 0.
REQ-032 SHALL, in reset, drive empty = 1, in_ready = 1, writeBackEn = 0, dest_wb = 0, result_WB = 0, hit1 = hit2 = 0, fwd1 = fwd2 = 0.
REQ-033 SHALL, on reset assertion mid-operation, discard all pending entries; no write is issued for them.

Configuration
REQ-034 SHALL, with macro WB_BYPASS_EN defined, implement lookup per REQ-028/029.
REQ-035 SHALL, without WB_BYPASS_EN, tie hit1, hit2, fwd1, fwd2 to 0, omit the compare logic and keep all ports present.

Verification
REQ-036 SHALL cover: push dest 3 data 0x11 while drain_hold = 1 -> count 1, writeBackEn 0; release hold -> writeBackEn 1, dest_wb 3, result_WB 0x11 for one cycle, then empty = 1.
REQ-037 SHALL cover: hold = 1, push 4 requests -> in_ready 0, count 4; 5th in_valid not accepted; release -> writes drain in order over 4 cycles.
REQ-038 SHALL cover: push (5,0xA) then (5,0xB), src1 = 5 -> hit1 1, fwd1 0xB; src2 = 6 -> hit2 0, fwd2 0 (WB_BYPASS_EN defined).
REQ-039 SHALL cover: count 2, simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap, write order matches push order.
REQ-040 SHALL cover: count 3, rst asserted low between edges -> empty 1, writeBackEn 0 immediately; no queued write after release.
REQ-041 SHALL cover: WB_BYPASS_EN undefined, repeat REQ-038 -> hit1 0, fwd1 0, drain behaviour unchanged.
